// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its backing store.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MWIDTH       = 64;
  localparam int unsigned OFFSET_WIDTH = 3;
  localparam int unsigned CNT_WIDTH    = 4;

endpackage

// File: rtl/dmem_block_ram.sv
// Single-port block store: synchronous write, registered read; contents survive reset.
module dmem_block_ram #(
  parameter int unsigned MWIDTH = 64,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [MWIDTH-1:0] i_wdata,
  output logic [MWIDTH-1:0] o_rdata
);

  logic [MWIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [MWIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Only the read register is reset; the array itself keeps its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency block memory responder for data-cache refills and writebacks.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned NBLOCKS = 1024,
  parameter int unsigned MWIDTH  = dmem_responder_pkg::MWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [MWIDTH-1:0] wdata,
  output logic              busy,
  output logic              countdone,
  output logic [MWIDTH-1:0] dout_mem
);

  localparam int unsigned AW = $clog2(NBLOCKS);

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [AW-1:0]          r_index;
  logic                   r_we;
  logic [MWIDTH-1:0]      r_wdata;
  logic                   w_mem_en;
  logic [AW-1:0]          w_index;
  logic                   w_unused_addr;

  // Block index drops the byte offset; bits above the store size wrap away.
  assign w_index       = req_addr[OFFSET_WIDTH +: AW];
  assign w_unused_addr = ^{req_addr[31:OFFSET_WIDTH+AW], req_addr[OFFSET_WIDTH-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_index <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_index <= w_index;
            r_we    <= req_we;
            r_wdata <= wdata;
            r_cnt   <= CNT_WIDTH'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    countdone = 1'b0;
    w_mem_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_next   = DONE;
          w_mem_en = 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        countdone = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  dmem_block_ram #(
    .MWIDTH (MWIDTH),
    .DEPTH  (NBLOCKS),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_mem_en),
    .i_we    (r_we),
    .i_addr  (r_index),
    .i_wdata (r_wdata),
    .o_rdata (dout_mem)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 main instance plus a LATENCY=1 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr;
  logic [63:0] wdata;
  logic        busy, countdone;
  logic [63:0] dout_mem;

  logic        v1, we1;
  logic [31:0] addr1;
  logic [63:0] wd1;
  logic        busy1, done1;
  logic [63:0] dout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(4), .NBLOCKS(1024), .MWIDTH(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .wdata(wdata), .busy(busy), .countdone(countdone),
    .dout_mem(dout_mem)
  );

  dmem_responder #(.LATENCY(1), .NBLOCKS(1024), .MWIDTH(64)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_we(we1),
    .req_addr(addr1), .wdata(wd1), .busy(busy1), .countdone(done1),
    .dout_mem(dout1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          glitch_k;
    logic [63:0] exp_dout;
  } vec_t;

  vec_t vecs[9];

  // One transaction on the LATENCY=4 instance; samples at negedges, k=1 is the cycle after acceptance.
  task automatic run_txn(input vec_t v, input int idx);
    int done_k, done_n, busy_n;
    done_k = 0; done_n = 0; busy_n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      if (countdone) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (busy) busy_n++;
      if (v.glitch_k != 0 && k == v.glitch_k) req_valid = 1'b1;
      else req_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
    end
    check($sformatf("v%0d done_cycle", idx), 64'(done_k), 64'd5);
    check($sformatf("v%0d done_pulses", idx), 64'(done_n), 64'd1);
    check($sformatf("v%0d busy_cycles", idx), 64'(busy_n), 64'd5);
    check($sformatf("v%0d dout", idx), dout_mem, v.exp_dout);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_dout;
  } op_t;

  op_t ops[5];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0010, 64'h0, 0, 64'h0};
    vecs[1] = '{1'b1, 32'h0000_0040, 64'h1111_2222_3333_4444, 0, 64'h0};
    vecs[2] = '{1'b0, 32'h0000_0044, 64'h0, 0, 64'h1111_2222_3333_4444};
    vecs[3] = '{1'b1, 32'h0000_2008, 64'hA5A5_0F0F_1234_5678, 0, 64'h1111_2222_3333_4444};
    vecs[4] = '{1'b0, 32'h0000_0008, 64'h0, 0, 64'hA5A5_0F0F_1234_5678};
    vecs[5] = '{1'b0, 32'h0000_0040, 64'h0, 2, 64'h1111_2222_3333_4444};
    vecs[6] = '{1'b0, 32'h0000_0000, 64'h0, 0, 64'h0};
    vecs[7] = '{1'b0, 32'hFFFF_E008, 64'h0, 0, 64'hA5A5_0F0F_1234_5678};
    vecs[8] = '{1'b1, 32'h0000_0040, 64'h0BAD_F00D_0000_0000, 2, 64'hA5A5_0F0F_1234_5678};

    ops[0] = '{1'b1, 32'h0000_0008, 64'h5555_6666_7777_8888, 64'h0};
    ops[1] = '{1'b0, 32'h0000_0008, 64'h0, 64'h5555_6666_7777_8888};
    ops[2] = '{1'b0, 32'h0000_0010, 64'h0, 64'h0};
    ops[3] = '{1'b0, 32'h0000_000C, 64'h0, 64'h5555_6666_7777_8888};
    ops[4] = '{1'b0, 32'h0000_0018, 64'h0, 64'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; wdata = '0;
    v1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst countdone", 64'(countdone), 64'd0);
    check("rst dout", dout_mem, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

    // Reset two cycles into a write must abort it before commit.
    begin
      int done_n;
      done_n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; wdata = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort busy_in_rst", 64'(busy), 64'd0);
      check("abort dout_in_rst", dout_mem, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (countdone) done_n++;
        @(negedge clk);
      end
      check("abort no_countdone", 64'(done_n), 64'd0);
    end
    run_txn('{1'b0, 32'h0000_0080, 64'h0, 0, 64'h0}, 100);

    // LATENCY=1 with req_valid held high: completions every 3 cycles.
    begin
      int n, last_t;
      n = 0; last_t = 0;
      @(negedge clk);
      v1 = 1'b1; we1 = ops[0].we; addr1 = ops[0].addr; wd1 = ops[0].wdata;
      for (int t = 1; t <= 40 && n < 5; t++) begin
        @(negedge clk);
        if (done1) begin
          check($sformatf("l1 dout%0d", n), dout1, ops[n].exp_dout);
          if (n > 0) check($sformatf("l1 gap%0d", n), 64'(t - last_t), 64'd3);
          last_t = t;
          n++;
          if (n < 5) begin
            we1 = ops[n].we; addr1 = ops[n].addr; wd1 = ops[n].wdata;
          end else begin
            v1 = 1'b0;
          end
        end
      end
      v1 = 1'b0;
      check("l1 completions", 64'(n), 64'd5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
